// File: rtl/dma_bus_arbiter_if.sv
// rtl/dma_bus_arbiter_if.sv - CRTC / Z80 / RAM signal bundle for the DMA bus arbiter
interface dma_bus_arbiter_if;
  logic        crtc_busreq;
  logic        crtc_busack;
  logic [16:0] crtc_adr;
  logic [7:0]  crtc_data;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [16:0] cpu_adr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [16:0] ram_adr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        dma_active;
  logic        timeout_err;

  modport master (
    output crtc_busreq, crtc_adr, cpu_busak_n, cpu_adr, cpu_we, cpu_wdata, ram_rdata,
    input  crtc_busack, crtc_data, cpu_busrq_n, cpu_rdata, ram_adr, ram_we, ram_wdata,
           dma_active, timeout_err
  );

  modport slave (
    input  crtc_busreq, crtc_adr, cpu_busak_n, cpu_adr, cpu_we, cpu_wdata, ram_rdata,
    output crtc_busack, crtc_data, cpu_busrq_n, cpu_rdata, ram_adr, ram_we, ram_wdata,
           dma_active, timeout_err
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - hands main RAM from the Z80 to the CRTC DMA engine via BUSRQ/BUSAK
module dma_bus_arbiter #(
  parameter int WAIT_LIMIT = 64,
  parameter int MIN_GAP    = 4
) (
  input logic              clk,
  input logic              rst_n,
  dma_bus_arbiter_if.slave bus
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam int GCW = $clog2(MIN_GAP + 1);
  localparam logic [WCW-1:0] WAIT_MAX  = WCW'(WAIT_LIMIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);
  localparam logic [GCW-1:0] GAP_MAX   = GCW'(MIN_GAP);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_REL} state_t;

  state_t         state, state_nxt;
  logic           busrq_n_q, busrq_n_nxt;
  logic           busack_q, busack_nxt;
  logic           active_q, active_nxt;
  logic           tmo_q, tmo_nxt;
  logic [GCW-1:0] gap_q, gap_nxt;
  logic [WCW-1:0] wait_q, wait_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busrq_n_q <= 1'b1;
      busack_q  <= 1'b0;
      active_q  <= 1'b0;
      tmo_q     <= 1'b0;
      gap_q     <= GAP_MAX;
      wait_q    <= '0;
    end else begin
      state     <= state_nxt;
      busrq_n_q <= busrq_n_nxt;
      busack_q  <= busack_nxt;
      active_q  <= active_nxt;
      tmo_q     <= tmo_nxt;
      gap_q     <= gap_nxt;
      wait_q    <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busrq_n_nxt = busrq_n_q;
    busack_nxt  = busack_q;
    active_nxt  = active_q;
    tmo_nxt     = tmo_q;
    gap_nxt     = gap_q;
    wait_nxt    = wait_q;
    case (state)
      S_IDLE: begin
        if (bus.crtc_busreq && (gap_q == GAP_MAX)) begin
          state_nxt   = S_REQ;
          busrq_n_nxt = 1'b0;
          wait_nxt    = '0;
        end else if (gap_q != GAP_MAX) begin
          gap_nxt = gap_q + GCW'(1);
        end
      end
      S_REQ: begin
        if (wait_q != WAIT_MAX) wait_nxt = wait_q + WCW'(1);
        if (!bus.cpu_busak_n) begin
          state_nxt  = S_GRANT;
          busack_nxt = 1'b1;
          active_nxt = 1'b1;
        end else begin
          // Timeout only flags; the CPU keeps the bus until it acknowledges.
          if (wait_q == WAIT_LAST) tmo_nxt = 1'b1;
          if (!bus.crtc_busreq) begin
            state_nxt   = S_REL;
            busrq_n_nxt = 1'b1;
          end
        end
      end
      S_GRANT: begin
        if (!bus.crtc_busreq) begin
          state_nxt   = S_REL;
          busack_nxt  = 1'b0;
          active_nxt  = 1'b0;
          busrq_n_nxt = 1'b1;
        end
      end
      S_REL: begin
        if (bus.cpu_busak_n) begin
          state_nxt = S_IDLE;
          gap_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.cpu_busrq_n = busrq_n_q;
  assign bus.crtc_busack = busack_q;
  assign bus.dma_active  = active_q;
  assign bus.timeout_err = tmo_q;

  // The mux select is the registered dma_active, so RAM steering never glitches mid-cycle.
  assign bus.ram_adr   = active_q ? bus.crtc_adr : bus.cpu_adr;
  assign bus.ram_we    = active_q ? 1'b0 : bus.cpu_we;
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.crtc_data = bus.ram_rdata;
  assign bus.cpu_rdata = bus.ram_rdata;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [7:0] mem [0:131071];

  dma_bus_arbiter_if bus ();

  dma_bus_arbiter #(.WAIT_LIMIT(64), .MIN_GAP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_adr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_adr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.crtc_busreq = 1'b0; bus.crtc_adr = '0;
    bus.cpu_busak_n = 1'b1; bus.cpu_adr = '0; bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL reset_busrq_n: got %b want 1", bus.cpu_busrq_n); end
    n_cmp++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL reset_busack: got %b want 0", bus.crtc_busack); end
    n_cmp++; if (bus.dma_active !== 1'b0) begin n_fail++; $display("FAIL reset_dma_active: got %b want 0", bus.dma_active); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_err); end
  endtask

  task automatic test_idle_write();
    bus.cpu_we = 1'b1; bus.cpu_adr = 17'h01234; bus.cpu_wdata = 8'hA5;
    #1;
    n_cmp++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL idle_ram_we: got %b want 1", bus.ram_we); end
    n_cmp++; if (bus.ram_adr !== 17'h01234) begin n_fail++; $display("FAIL idle_ram_adr: got %h want 01234", bus.ram_adr); end
    n_cmp++; if (bus.ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL idle_ram_wdata: got %h want a5", bus.ram_wdata); end
    tick();
    bus.cpu_we = 1'b0;
    tick();
    n_cmp++; if (bus.cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL idle_readback: got %h want a5", bus.cpu_rdata); end
    bus.cpu_adr = '0;
  endtask

  task automatic test_basic_grant();
    bus.crtc_adr = 17'h0F300;
    bus.crtc_busreq = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL grant_busrq_c%0d: got %b want 0", c, bus.cpu_busrq_n); end
      n_cmp++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL grant_early_ack_c%0d: got %b want 0", c, bus.crtc_busack); end
    end
    bus.cpu_busak_n = 1'b0;
    tick();
    n_cmp++; if (bus.crtc_busack !== 1'b1) begin n_fail++; $display("FAIL grant_ack: got %b want 1", bus.crtc_busack); end
    n_cmp++; if (bus.dma_active !== 1'b1) begin n_fail++; $display("FAIL grant_active: got %b want 1", bus.dma_active); end
    n_cmp++; if (bus.ram_adr !== 17'h0F300) begin n_fail++; $display("FAIL grant_ram_adr: got %h want 0f300", bus.ram_adr); end
    tick();
    n_cmp++; if (bus.crtc_data !== 8'hF3) begin n_fail++; $display("FAIL grant_crtc_data: got %h want f3", bus.crtc_data); end
  endtask

  task automatic test_write_block();
    bus.cpu_we = 1'b1; bus.cpu_adr = 17'h01234; bus.cpu_wdata = 8'h5A;
    #1;
    n_cmp++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL block_ram_we: got %b want 0", bus.ram_we); end
    n_cmp++; if (bus.ram_adr !== 17'h0F300) begin n_fail++; $display("FAIL block_ram_adr: got %h want 0f300", bus.ram_adr); end
    bus.cpu_we = 1'b0;
  endtask

  task automatic test_release_gap();
    bus.crtc_busreq = 1'b0;
    tick();
    n_cmp++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL rel_ack: got %b want 0", bus.crtc_busack); end
    n_cmp++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL rel_busrq_n: got %b want 1", bus.cpu_busrq_n); end
    n_cmp++; if (bus.dma_active !== 1'b0) begin n_fail++; $display("FAIL rel_active: got %b want 0", bus.dma_active); end
    tick();
    bus.cpu_busak_n = 1'b1;
    bus.crtc_busreq = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL gap_hold_c%0d: got %b want 1", c, bus.cpu_busrq_n); end
    end
    tick();
    n_cmp++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL gap_rerequest: got %b want 0", bus.cpu_busrq_n); end
  endtask

  task automatic test_back_to_back();
    bus.cpu_busak_n = 1'b0;
    tick();
    n_cmp++; if (bus.crtc_busack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack: got %b want 1", bus.crtc_busack); end
    bus.crtc_busreq = 1'b0;
    bus.cpu_busak_n = 1'b1;
    tick();
    n_cmp++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL b2b_rel_ack: got %b want 0", bus.crtc_busack); end
    bus.crtc_busreq = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_c%0d: got %b want 1", c, bus.cpu_busrq_n); end
    end
    tick();
    n_cmp++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL b2b_rerequest: got %b want 0", bus.cpu_busrq_n); end
    bus.crtc_busreq = 1'b0;
    tick();
    n_cmp++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL b2b_abandon: got %b want 1", bus.cpu_busrq_n); end
    tick();
  endtask

  task automatic test_abandon();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.crtc_busreq = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL abandon_req: got %b want 0", bus.cpu_busrq_n); end
    bus.crtc_busreq = 1'b0;
    tick();
    n_cmp++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL abandon_busrq_n: got %b want 1", bus.cpu_busrq_n); end
    bus.crtc_busreq = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++; if ({bus.cpu_busrq_n, bus.crtc_busack} !== 2'b10) begin n_fail++; $display("FAIL abandon_gap_c%0d: got %b want 10", c, {bus.cpu_busrq_n, bus.crtc_busack}); end
    end
    tick();
    n_cmp++; if (bus.cpu_busrq_n !== 1'b0) begin n_fail++; $display("FAIL abandon_idle_reached: got %b want 0", bus.cpu_busrq_n); end
    bus.crtc_busreq = 1'b0;
    tick(); tick();
  endtask

  task automatic test_spurious();
    bus.cpu_busak_n = 1'b0;
    tick();
    bus.cpu_busak_n = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_cmp++; if ({bus.cpu_busrq_n, bus.crtc_busack, bus.dma_active} !== 3'b100) begin n_fail++; $display("FAIL spurious_c%0d: got %b want 100", c, {bus.cpu_busrq_n, bus.crtc_busack, bus.dma_active}); end
    end
  endtask

  task automatic test_timeout();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.cpu_busak_n = 1'b1;
    bus.crtc_busreq = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      n_cmp++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL tmo_no_grant_%0d: got %b want 0", i, bus.crtc_busack); end
      if (i == 64) begin
        n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", bus.timeout_err); end
      end
      if (i == 65) begin
        n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", bus.timeout_err); end
      end
    end
    bus.cpu_busak_n = 1'b0;
    tick();
    n_cmp++; if (bus.crtc_busack !== 1'b1) begin n_fail++; $display("FAIL tmo_late_grant: got %b want 1", bus.crtc_busack); end
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", bus.timeout_err); end
  endtask

  task automatic test_reset_mid_grant();
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.crtc_busack !== 1'b0) begin n_fail++; $display("FAIL async_ack: got %b want 0", bus.crtc_busack); end
    n_cmp++; if (bus.cpu_busrq_n !== 1'b1) begin n_fail++; $display("FAIL async_busrq_n: got %b want 1", bus.cpu_busrq_n); end
    n_cmp++; if (bus.dma_active !== 1'b0) begin n_fail++; $display("FAIL async_active: got %b want 0", bus.dma_active); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL async_timeout: got %b want 0", bus.timeout_err); end
    bus.crtc_busreq = 1'b0;
    bus.cpu_busak_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'(i[7:0] ^ i[15:8] ^ {7'b0, i[16]});
    test_reset();
    test_idle_write();
    test_basic_grant();
    test_write_block();
    test_release_gap();
    test_back_to_back();
    test_abandon();
    test_spurious();
    test_timeout();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
